// File: rtl/mem_arbiter_pkg.sv
// Shared CPU definitions for the memory arbiter: FSM encoding, cache block
// geometry and the address helpers used to walk a block.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IFILL  = 2'd1,
        S_DFILL  = 2'd2,
        S_DWRITE = 2'd3
    } arb_state_t;

    localparam int          BLOCK_WORDS = 8;
    localparam int          CNT_W       = 4;
    localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;

    // Byte offset of a 16-bit word inside a block.
    function automatic logic [15:0] word_offset(input logic [CNT_W-1:0] idx);
        return {11'd0, idx, 1'b0};
    endfunction

endpackage

// File: rtl/mem_arbiter_fill_ctr.sv
// Issue/receive counter pair for a block fill; both clear together when the
// arbiter is idle and advance independently.
module arb_fill_ctr
    import mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             issue_inc,
    input  logic             recv_inc,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] recv_cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            if (issue_inc) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (recv_inc) begin
                recv_cnt <= recv_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills, D-cache fills and D-cache write-through stores
// onto one pipelined main-memory port; the D side always wins in IDLE.
module mem_arbiter #(
    parameter int BLOCK_WORDS = mem_arbiter_pkg::BLOCK_WORDS,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req,
    input  logic [DATA_W-1:0] ic_addr,
    input  logic              dc_req,
    input  logic              dc_wr,
    input  logic [DATA_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic [DATA_W-1:0] fill_addr,
    output logic              ic_fill_we,
    output logic              dc_fill_we,
    output logic              ic_done,
    output logic              dc_done,
    output logic              busy
);
    import mem_arbiter_pkg::*;

    localparam logic [CNT_W-1:0]  NUM_WORDS = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [DATA_W-1:0] ADDR_MASK = DATA_W'(BLOCK_MASK);

    arb_state_t        state;
    logic [DATA_W-1:0] base;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic              filling;
    logic              issue_more;
    logic              recv_word;
    logic              last_word;
    logic              ctr_clr;

    assign filling    = (state == S_IFILL) || (state == S_DFILL);
    assign issue_more = filling && (issue_cnt < NUM_WORDS);
    // Valids outside a fill (stale data after a reset, or during a store) are dropped here.
    assign recv_word  = filling && mem_data_valid;
    assign last_word  = recv_word && (recv_cnt == LAST_IDX);
    assign ctr_clr    = (state == S_IDLE);

    arb_fill_ctr u_fill_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (ctr_clr),
        .issue_inc (issue_more),
        .recv_inc  (recv_word),
        .issue_cnt (issue_cnt),
        .recv_cnt  (recv_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            base  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (dc_req) begin
                        state <= dc_wr ? S_DWRITE : S_DFILL;
                        base  <= dc_addr & ADDR_MASK;
                    end else if (ic_req) begin
                        state <= S_IFILL;
                        base  <= ic_addr & ADDR_MASK;
                    end
                end
                S_IFILL, S_DFILL: begin
                    if (last_word) begin
                        state <= S_IDLE;
                    end
                end
                S_DWRITE: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign fill_data = mem_rdata;
    assign busy      = (state != S_IDLE);

    always_comb begin
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_addr  = '0;
        ic_fill_we = 1'b0;
        dc_fill_we = 1'b0;
        ic_done    = 1'b0;
        dc_done    = 1'b0;
        unique case (state)
            S_IFILL, S_DFILL: begin
                if (issue_more) begin
                    mem_en   = 1'b1;
                    mem_addr = base + DATA_W'(word_offset(issue_cnt));
                end
                if (recv_word) begin
                    fill_addr  = base + DATA_W'(word_offset(recv_cnt));
                    ic_fill_we = (state == S_IFILL);
                    dc_fill_we = (state == S_DFILL);
                end
                ic_done = last_word && (state == S_IFILL);
                dc_done = last_word && (state == S_DFILL);
            end
            S_DWRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = dc_addr;
                mem_wdata = dc_wdata;
                dc_done   = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level schedule model feeds
// per-event-kind expectation queues, a negedge monitor pops and compares.
module tb_mem_arbiter;

    localparam int K_RD = 0, K_WR = 1, K_IF = 2, K_DF = 3, K_ID = 4, K_DD = 5, NK = 6;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    ev_t         exp_q [NK][$];
    bit          busy_exp [int];
    logic [15:0] rd_sched [int];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ic_req = 1'b0;
    logic [15:0] ic_addr = '0;
    logic        dc_req = 1'b0;
    logic        dc_wr = 1'b0;
    logic [15:0] dc_addr = '0;
    logic [15:0] dc_wdata = '0;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_data_valid = 1'b0;
    logic [15:0] fill_data, fill_addr;
    logic        ic_fill_we, dc_fill_we, ic_done, dc_done, busy;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;
    int idle_at = 0;
    bit mon_en = 1'b0;

    mem_arbiter #(.BLOCK_WORDS(8), .DATA_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .dc_req         (dc_req),
        .dc_wr          (dc_wr),
        .dc_addr        (dc_addr),
        .dc_wdata       (dc_wdata),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_data_valid (mem_data_valid),
        .fill_data      (fill_data),
        .fill_addr      (fill_addr),
        .ic_fill_we     (ic_fill_we),
        .dc_fill_we     (dc_fill_we),
        .ic_done        (ic_done),
        .dc_done        (dc_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return (a * 16'd7) ^ 16'hA5C3;
    endfunction

    // Memory: data for a read seen in cycle n is returned during cycle n+4.
    always @(posedge clk) begin
        #1;
        if (rd_sched.exists(cyc)) begin
            mem_data_valid = 1'b1;
            mem_rdata      = mem_fn(rd_sched[cyc]);
            rd_sched.delete(cyc);
        end else begin
            mem_data_valid = 1'b0;
            mem_rdata      = '0;
        end
    end

    // ---------------- reference model (schedule arithmetic) ----------------
    function automatic void push(int k, int c, logic [15:0] a, logic [15:0] d);
        ev_t e;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        exp_q[k].push_back(e);
    endfunction

    // Fill granted in IDLE cycle g; 'active' is how many cycles after g the fill runs (12 = complete).
    function automatic void model_fill(bit is_ic, int g, logic [15:0] addr, int active);
        logic [15:0] base = addr & 16'hFFF0;
        logic [15:0] a;
        for (int i = 0; i < 8; i++) begin
            a = base + 16'(2 * i);
            if (1 + i <= active) push(K_RD, g + 1 + i, a, 16'h0000);
            if (5 + i <= active) push(is_ic ? K_IF : K_DF, g + 5 + i, a, mem_fn(a));
        end
        if (active >= 12) push(is_ic ? K_ID : K_DD, g + 12, 16'h0000, 16'h0000);
        for (int i = 1; i <= active; i++) busy_exp[g + i] = 1'b1;
    endfunction

    function automatic void model_write(int g, logic [15:0] a, logic [15:0] d);
        push(K_WR, g + 1, a, d);
        push(K_DD, g + 1, 16'h0000, 16'h0000);
        busy_exp[g + 1] = 1'b1;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_ev(int k, string nm, logic [15:0] a, logic [15:0] d);
        ev_t e;
        n_assert++;
        if (exp_q[k].size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected at cycle %0d: addr %h data %h, expected no event", nm, cyc, a, d);
        end else begin
            e = exp_q[k].pop_front();
            if (e.cyc != cyc || e.addr !== a || e.data !== d) begin
                n_fail++;
                $display("FAIL %s: got cycle %0d addr %h data %h, expected cycle %0d addr %h data %h",
                         nm, cyc, a, d, e.cyc, e.addr, e.data);
            end
        end
    endtask

    task automatic zero_check(string nm);
        chk({nm, "_busy"}, 16'(busy), 16'h0);
        chk({nm, "_mem_en"}, 16'(mem_en), 16'h0);
        chk({nm, "_mem_wr"}, 16'(mem_wr), 16'h0);
        chk({nm, "_mem_addr"}, mem_addr, 16'h0);
        chk({nm, "_mem_wdata"}, mem_wdata, 16'h0);
        chk({nm, "_fill_addr"}, fill_addr, 16'h0);
        chk({nm, "_ic_fill_we"}, 16'(ic_fill_we), 16'h0);
        chk({nm, "_dc_fill_we"}, 16'(dc_fill_we), 16'h0);
        chk({nm, "_ic_done"}, 16'(ic_done), 16'h0);
        chk({nm, "_dc_done"}, 16'(dc_done), 16'h0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_en === 1'b1 && mem_wr === 1'b0) rd_sched[cyc + 4] = mem_addr;
            chk("busy", 16'(busy), 16'(busy_exp.exists(cyc)));
            chk("fill_data", fill_data, mem_rdata);
            if (mem_en === 1'b1) begin
                if (mem_wr === 1'b1) check_ev(K_WR, "mem_write", mem_addr, mem_wdata);
                else                 check_ev(K_RD, "mem_read", mem_addr, mem_wdata);
            end else begin
                chk("mem_wr_idle", 16'(mem_wr), 16'h0);
                chk("mem_addr_idle", mem_addr, 16'h0);
                chk("mem_wdata_idle", mem_wdata, 16'h0);
            end
            if (ic_fill_we === 1'b1) check_ev(K_IF, "ic_fill", fill_addr, fill_data);
            if (dc_fill_we === 1'b1) check_ev(K_DF, "dc_fill", fill_addr, fill_data);
            if (ic_fill_we !== 1'b1 && dc_fill_we !== 1'b1) chk("fill_addr_idle", fill_addr, 16'h0);
            if (ic_done === 1'b1) check_ev(K_ID, "ic_done", 16'h0, 16'h0);
            if (dc_done === 1'b1) check_ev(K_DD, "dc_done", 16'h0, 16'h0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic goto(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_ic(logic [15:0] a, int gap, bit early_drop);
        int c;
        goto(idle_at + gap);
        c = cyc;
        ic_req  = 1'b1;
        ic_addr = a;
        model_fill(1'b1, c, a, 12);
        $display("txn cycle %0d: IFILL addr %h%s", c, a, early_drop ? " (request dropped mid-fill)" : "");
        if (early_drop) begin
            goto(c + 1 + int'($urandom_range(0, 10)));
            ic_req  = 1'b0;
            ic_addr = 16'($urandom);
        end
        goto(c + 13);
        ic_req  = 1'b0;
        idle_at = c + 13;
    endtask

    task automatic run_dc(bit wr, logic [15:0] a, logic [15:0] d, int gap);
        int c;
        int fin;
        goto(idle_at + gap);
        c = cyc;
        dc_req   = 1'b1;
        dc_wr    = wr;
        dc_addr  = a;
        dc_wdata = d;
        if (wr) begin
            model_write(c, a, d);
            fin = c + 2;
        end else begin
            model_fill(1'b0, c, a, 12);
            fin = c + 13;
        end
        $display("txn cycle %0d: %s addr %h data %h", c, wr ? "DWRITE" : "DFILL", a, d);
        goto(fin);
        dc_req  = 1'b0;
        dc_wr   = 1'($urandom);
        idle_at = fin;
    endtask

    task automatic run_both(logic [15:0] ia, bit wr, logic [15:0] da, logic [15:0] dd, int gap);
        int c;
        int dfin;
        goto(idle_at + gap);
        c = cyc;
        ic_req   = 1'b1;
        ic_addr  = ia;
        dc_req   = 1'b1;
        dc_wr    = wr;
        dc_addr  = da;
        dc_wdata = dd;
        if (wr) begin
            model_write(c, da, dd);
            dfin = c + 2;
        end else begin
            model_fill(1'b0, c, da, 12);
            dfin = c + 13;
        end
        model_fill(1'b1, dfin, ia, 12);
        $display("txn cycle %0d: %s addr %h then IFILL addr %h", c, wr ? "DWRITE" : "DFILL", da, ia);
        goto(dfin);
        dc_req = 1'b0;
        goto(dfin + 13);
        ic_req  = 1'b0;
        idle_at = dfin + 13;
    endtask

    task automatic run_ic_reset(logic [15:0] a, int gap);
        int c;
        goto(idle_at + gap);
        c = cyc;
        ic_req  = 1'b1;
        ic_addr = a;
        model_fill(1'b1, c, a, 6);
        $display("txn cycle %0d: IFILL addr %h aborted by reset in cycle %0d", c, a, c + 6);
        goto(c + 6);
        rst_n  = 1'b0;
        ic_req = 1'b0;
        goto(c + 7);
        rst_n = 1'b1;
        @(negedge clk);
        zero_check("post_reset");
        // Let the stale returns of the abandoned fill drain while idle.
        idle_at = c + 11;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        zero_check("reset");
        idle_at = cyc + 1;

        run_ic(16'h0024, 0, 1'b0);
        run_both(16'h0300, 1'b0, 16'h1002, 16'h0000, 1);
        run_dc(1'b1, 16'h0100, 16'hBEEF, 1);
        run_ic_reset(16'h0040, 1);
        run_ic(16'h0500, 0, 1'b0);
        run_ic(16'h0610, 0, 1'b0);
        run_ic(16'hFFFA, 1, 1'b0);
        run_both(16'h0700, 1'b1, 16'h2222, 16'h1234, 0);

        for (int n = 0; n < 30; n++) begin
            int sel;
            int gap;
            sel = int'($urandom_range(0, 4));
            gap = int'($urandom_range(0, 3));
            case (sel)
                0: run_ic(16'($urandom), gap, 1'($urandom));
                1: run_dc(1'b0, 16'($urandom), 16'($urandom), gap);
                2: run_dc(1'b1, 16'($urandom), 16'($urandom), gap);
                3: run_both(16'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), gap);
                default: run_ic_reset(16'($urandom), gap);
            endcase
        end

        goto(idle_at + 6);
        for (int k = 0; k < NK; k++) begin
            n_assert++;
            if (exp_q[k].size() != 0) begin
                n_fail++;
                $display("FAIL missing_events kind %0d: got %0d left over, expected 0 (first due cycle %0d)",
                         k, exp_q[k].size(), exp_q[k][0].cyc);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BLOCK_WORDS, default 8: 16-bit words per cache block; the block SHALL support only 8.
REQ-002 Parameter DATA_W, default 16: data and address width.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port ic_req, input, 1: I-cache miss request, held high until ic_done.
REQ-006 Port ic_addr, input, 16: I-cache miss byte address.
REQ-007 Port dc_req, input, 1: D-cache request (miss fill or write-through store), held high until dc_done.
REQ-008 Port dc_wr, input, 1: 1 = store, 0 = fill; sampled with dc_req.
REQ-009 Port dc_addr, input, 16: D-side byte address.
REQ-010 Port dc_wdata, input, 16: store data.
REQ-011 Port mem_en / mem_wr, output, 1 each: main-memory request strobe and write select.
REQ-012 Port mem_addr / mem_wdata, output, 16 each: memory byte address and write data.
REQ-013 Port mem_rdata, input, 16: memory read data.
REQ-014 Port mem_data_valid, input, 1: mem_rdata valid. Memory is pipelined, accepts one read per cycle and returns data 4 cycles after issue, in order.
REQ-015 Port fill_data, output, 16: mem_rdata forwarded to both caches.
REQ-016 Port fill_addr, output, 16: byte address of the current fill word.
REQ-017 Port ic_fill_we / dc_fill_we, output, 1 each: write fill_data into that cache.
REQ-018 Port ic_done / dc_done, output, 1 each: one-cycle completion pulse.
REQ-019 Port busy, output, 1: high whenever state is not IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, IFILL, DFILL and DWRITE.
REQ-021 IDLE: dc_req&dc_wr -> DWRITE; dc_req&~dc_wr -> DFILL; else ic_req -> IFILL. D always beats I; the losing I request stays pending.
REQ-022 On leaving IDLE, the block SHALL latch base = addr & 16'hFFF0 and clear issue_cnt and recv_cnt (4 bits each).
REQ-023 FILL states: while issue_cnt<8, assert mem_en=1, mem_wr=0 and mem_addr=base+2*issue_cnt, then increment issue_cnt; reads go out on 8 consecutive cycles.
REQ-024 FILL states: when mem_data_valid is high, assert the owner's fill_we, drive fill_addr=base+2*recv_cnt and increment recv_cnt.
REQ-025 The cycle the 8th word arrives (recv_cnt==7 & valid) SHALL also pulse the owner's done; the next state is IDLE.
REQ-026 Timing: request seen in IDLE at cycle 0 -> reads issued in cycles 1-8 -> data in cycles 5-12 -> done in cycle 12 -> IDLE in cycle 13.
REQ-027 DWRITE, one cycle: mem_en=1, mem_wr=1, mem_addr=dc_addr, mem_wdata=dc_wdata, dc_done=1; next state IDLE.
REQ-028 Requests are not re-sampled outside IDLE; deasserting a request mid-fill SHALL NOT abort the fill.
REQ-029 Minimum one IDLE cycle between grants; a pending ic_req is granted in that cycle if dc_req is low.
REQ-030 mem_data_valid seen in IDLE or DWRITE SHALL be ignored, with no fill_we.
REQ-031 When not driven, outputs SHALL be 0; fill_data SHALL always equal mem_rdata.

Reset
REQ-032 While rst_n=0 at a clock edge: state=IDLE, counters=0, base=0; every output SHALL read 0 in the following cycle.
REQ-033 Reset mid-fill SHALL abandon the fill with no done pulse; stale returning data SHALL be ignored per REQ-030.

Structure
REQ-034 State encodings, BLOCK_WORDS and the block-offset mask SHALL live in the shared CPU definitions package.
REQ-035 One sub-module, arb_fill_ctr, SHALL implement the issue/receive counter pair with clear and increment controls.

Verification
REQ-036 I fill only: ic_req with ic_addr=16'h0024 -> reads 0x0020..0x002E in cycles 1-8, 8 ic_fill_we, ic_done in cycle 12.
REQ-037 Simultaneous ic_req and dc_req (fill, dc_addr=16'h1002) -> DFILL of 0x1000 first, then IFILL starts after one IDLE cycle.
REQ-038 Store: dc_req, dc_wr=1, dc_addr=16'h0100, dc_wdata=16'hBEEF -> one cycle with mem_en=1, mem_wr=1 and those values, with dc_done.
REQ-039 rst_n low in cycle 6 of an IFILL -> IDLE, no ic_done, and the remaining returned valids produce no fill_we.
REQ-040 Back-to-back: ic_req held and re-asserted after done -> second IFILL starts exactly one cycle after the first returns to IDLE.
REQ-041 Address wrap: ic_addr=16'hFFFA -> reads 0xFFF0..0xFFFE with no overflow past 0xFFFE.
